// File: rtl/mul_fu_ctrl.sv
// mul_fu_ctrl: one-deep multiply controller that sign-converts operands, waits LAT cycles and holds the product for write-back.
module mul_fu_ctrl #(
   parameter int WIDTH = 16,
   parameter int LAT   = 3,
   parameter int TAG_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_valid,
   output logic               issue_ready,
   input  logic               issue_signed,
   input  logic [WIDTH-1:0]   issue_a,
   input  logic [WIDTH-1:0]   issue_b,
   input  logic [TAG_W-1:0]   issue_tag,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_p,
   output logic               wb_req,
   input  logic               wb_grant,
   output logic [2*WIDTH-1:0] wb_data,
   output logic [TAG_W-1:0]   wb_tag,
   output logic               busy,
   input  logic               flush
);
   typedef enum logic [1:0] {IDLE, EXEC, WAIT_WB} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [2*WIDTH-1:0] wb_data_q, wb_data_d;
   logic [TAG_W-1:0]   tag_q, tag_d, wb_tag_q, wb_tag_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               neg_q, neg_d, wb_req_q, wb_req_d;
   assign issue_ready = (state_q == IDLE) & ~flush;
   assign busy        = state_q != IDLE;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign wb_req      = wb_req_q;
   assign wb_data     = wb_data_q;
   assign wb_tag      = wb_tag_q;
   always_comb begin
      state_d   = state_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      wb_data_d = wb_data_q;
      tag_d     = tag_q;
      wb_tag_d  = wb_tag_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      wb_req_d  = wb_req_q;
      if (flush) begin
         state_d  = IDLE;
         wb_req_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (issue_valid) begin
               mul_a_d = (issue_signed & issue_a[WIDTH-1]) ? WIDTH'(-issue_a) : issue_a;
               mul_b_d = (issue_signed & issue_b[WIDTH-1]) ? WIDTH'(-issue_b) : issue_b;
               neg_d   = issue_signed & (issue_a[WIDTH-1] ^ issue_b[WIDTH-1]);
               tag_d   = issue_tag;
               cnt_d   = 4'(LAT - 1);
               state_d = EXEC;
            end
            EXEC: if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               wb_data_d = neg_q ? -mul_p : mul_p;
               wb_tag_d  = tag_q;
               wb_req_d  = 1'b1;
               state_d   = WAIT_WB;
            end
            WAIT_WB: if (wb_grant) begin
               wb_req_d = 1'b0;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         wb_data_q <= '0;
         tag_q     <= '0;
         wb_tag_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         wb_req_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         wb_data_q <= wb_data_d;
         tag_q     <= tag_d;
         wb_tag_q  <= wb_tag_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         wb_req_q  <= wb_req_d;
      end
   end
endmodule

// File: tb/tb_mul_fu_ctrl.sv
// tb_mul_fu_ctrl: directed steps against mul_fu_ctrl with a behavioural multiplier on mul_p.
module tb_mul_fu_ctrl;
   localparam int LAT = 3;
   logic        clk = 1'b0;
   logic        rst_n, issue_valid, issue_ready, issue_signed, wb_req, wb_grant, busy, flush;
   logic [15:0] issue_a, issue_b, mul_a, mul_b;
   logic [31:0] mul_p, wb_data;
   logic [2:0]  issue_tag, wb_tag;
   int          checks = 0;
   int          errors = 0;
   mul_fu_ctrl #(.WIDTH(16), .LAT(LAT), .TAG_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_signed(issue_signed), .issue_a(issue_a), .issue_b(issue_b), .issue_tag(issue_tag),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .wb_req(wb_req), .wb_grant(wb_grant),
      .wb_data(wb_data), .wb_tag(wb_tag), .busy(busy), .flush(flush)
   );
   assign mul_p = mul_a * mul_b;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [2:0] t);
      issue_valid  = 1'b1;
      issue_signed = s;
      issue_a      = a;
      issue_b      = b;
      issue_tag    = t;
   endtask
   task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [2:0] t,
                         input logic [15:0] ema, input logic [15:0] emb, input logic [31:0] ed);
      drive(s, a, b, t);
      chk("ready_pre", issue_ready, 1);
      tick();
      issue_valid = 1'b0;
      chk("busy_acc", busy, 1);
      chk("mul_a", mul_a, ema);
      chk("mul_b", mul_b, emb);
      repeat (LAT - 1) begin
         tick();
         chk("req_early", wb_req, 0);
         chk("ready_exec", issue_ready, 0);
      end
      tick();
      chk("req_rise", wb_req, 1);
      chk("wb_data", wb_data, ed);
      chk("wb_tag", wb_tag, t);
      wb_grant = 1'b1;
      tick();
      wb_grant = 1'b0;
      chk("req_drop", wb_req, 0);
      chk("idle_busy", busy, 0);
   endtask
   initial begin
      rst_n = 1'b0; issue_valid = 1'b0; issue_signed = 1'b0; issue_a = '0; issue_b = '0;
      issue_tag = '0; wb_grant = 1'b0; flush = 1'b0;
      tick(); tick();
      chk("rst_req", wb_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_tag", wb_tag, 0);
      rst_n = 1'b1;
      chk("rst_ready", issue_ready, 1);
      // unsigned max operands, result held across a stalled grant
      drive(1'b0, 16'hFFFF, 16'hFFFF, 3'd5);
      tick();
      issue_valid = 1'b0;
      chk("u_mul_a", mul_a, 16'hFFFF);
      tick(); chk("u_req0", wb_req, 0);
      tick(); chk("u_req1", wb_req, 0);
      tick();
      chk("u_req", wb_req, 1);
      chk("u_data", wb_data, 32'hFFFE0001);
      chk("u_tag", wb_tag, 5);
      repeat (4) begin
         tick();
         chk("u_hold_req", wb_req, 1);
         chk("u_hold_data", wb_data, 32'hFFFE0001);
         chk("u_hold_tag", wb_tag, 5);
         chk("u_hold_ready", issue_ready, 0);
      end
      wb_grant = 1'b1;
      tick();
      wb_grant = 1'b0;
      chk("u_done_req", wb_req, 0);
      chk("u_done_ready", issue_ready, 1);
      run_op(1'b1, 16'hFFFD, 16'h0007, 3'd2, 16'h0003, 16'h0007, 32'hFFFFFFEB);
      run_op(1'b1, 16'h8000, 16'h8000, 3'd3, 16'h8000, 16'h8000, 32'h40000000);
      run_op(1'b1, 16'h8000, 16'h0001, 3'd4, 16'h8000, 16'h0001, 32'hFFFF8000);
      run_op(1'b1, 16'h0000, 16'hFFFF, 3'd6, 16'h0000, 16'h0001, 32'h00000000);
      run_op(1'b0, 16'h8000, 16'h0003, 3'd1, 16'h8000, 16'h0003, 32'h00018000);
      // issue_valid held high: second accept only after the grant cycle
      drive(1'b0, 16'd2, 16'd3, 3'd1);
      tick();
      drive(1'b0, 16'd4, 16'd5, 3'd2);
      repeat (LAT) begin
         chk("hs_ready", issue_ready, 0);
         tick();
      end
      chk("hs_req", wb_req, 1);
      chk("hs_data", wb_data, 32'd6);
      wb_grant = 1'b1;
      tick();
      wb_grant = 1'b0;
      chk("hs_no_acc_busy", busy, 0);
      chk("hs_no_acc_a", mul_a, 16'd2);
      chk("hs_ready_up", issue_ready, 1);
      tick();
      issue_valid = 1'b0;
      chk("hs_acc2_busy", busy, 1);
      chk("hs_acc2_a", mul_a, 16'd4);
      repeat (LAT) tick();
      chk("hs2_data", wb_data, 32'd20);
      chk("hs2_tag", wb_tag, 2);
      wb_grant = 1'b1;
      tick();
      wb_grant = 1'b0;
      // flush in the second EXEC cycle
      drive(1'b0, 16'd7, 16'd9, 3'd7);
      tick();
      issue_valid = 1'b0;
      tick();
      flush = 1'b1;
      chk("fl_ready", issue_ready, 0);
      tick();
      flush = 1'b0;
      chk("fl_busy", busy, 0);
      chk("fl_mul_a", mul_a, 16'd7);
      repeat (3) begin
         tick();
         chk("fl_no_req", wb_req, 0);
      end
      // flush coincident with grant
      drive(1'b0, 16'd10, 16'd11, 3'd3);
      tick();
      issue_valid = 1'b0;
      repeat (LAT) tick();
      chk("fg_req", wb_req, 1);
      wb_grant = 1'b1;
      flush = 1'b1;
      tick();
      wb_grant = 1'b0;
      flush = 1'b0;
      chk("fg_req_drop", wb_req, 0);
      chk("fg_busy", busy, 0);
      chk("fg_data_kept", wb_data, 32'd110);
      // flush blocks an accept in IDLE
      drive(1'b1, 16'h1234, 16'h0002, 3'd4);
      flush = 1'b1;
      chk("fi_ready", issue_ready, 0);
      tick();
      issue_valid = 1'b0;
      flush = 1'b0;
      chk("fi_busy", busy, 0);
      chk("fi_mul_a", mul_a, 16'd10);
      // reset mid-EXEC overrides grant and flush
      drive(1'b1, 16'hFFFE, 16'h0005, 3'd6);
      tick();
      issue_valid = 1'b0;
      chk("re_busy", busy, 1);
      rst_n = 1'b0;
      wb_grant = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      wb_grant = 1'b0;
      chk("re_req", wb_req, 0);
      chk("re_data", wb_data, 0);
      chk("re_mul_a", mul_a, 0);
      chk("re_tag", wb_tag, 0);
      chk("re_busy0", busy, 0);
      chk("re_ready", issue_ready, 1);
      repeat (LAT + 1) tick();
      chk("re_stay_idle", wb_req, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul_fu_ctrl.md
Name: mul_fu_ctrl

Overview:
- Multiply functional-unit controller. Sits between the scoreboard issue logic and the combinational 16x16 unsigned Wallace multiplier.
- Accepts one issued multiply at a time and converts signed operands to magnitudes before driving the multiplier.
- Holds the operands stable for a fixed number of cycles, then captures and sign-corrects the 32-bit product.
- Presents the result to the write-back arbiter with a tag, and holds it until granted.

Parameters:
- WIDTH, 16, operand width; product width is 2*WIDTH.
- LAT, 3, cycles operands are held on the multiplier before the product is captured (legal range 1..15).
- TAG_W, 3, destination-register tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- issue_valid  in  1  scoreboard presents a multiply.
- issue_ready  out  1  unit can accept; high only in IDLE.
- issue_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- issue_a  in  WIDTH  operand A.
- issue_b  in  WIDTH  operand B.
- issue_tag  in  TAG_W  destination tag.
- mul_a  out  WIDTH  registered magnitude of A, to multiplier input a.
- mul_b  out  WIDTH  registered magnitude of B, to multiplier input b.
- mul_p  in  2*WIDTH  unsigned product returned by the multiplier.
- wb_req  out  1  result valid, requesting write-back.
- wb_grant  in  1  arbiter accepts the result this cycle.
- wb_data  out  2*WIDTH  signed or unsigned final product.
- wb_tag  out  TAG_W  tag of the held result.
- busy  out  1  high in EXEC or WAIT_WB (scoreboard FU-busy bit).
- flush  in  1  abandon the in-flight operation.

Behaviour:
- Reset: rst_n low at a rising edge sets the state to IDLE. All registered outputs clear: mul_a=0, mul_b=0, wb_req=0, wb_data=0, wb_tag=0, neg flag=0, counter=0. Reset overrides flush, issue and grant, including mid-operation.
- States: IDLE, EXEC, WAIT_WB. issue_ready = (state==IDLE) & ~flush. busy = (state!=IDLE).
- IDLE -> EXEC on an edge with issue_valid & issue_ready.
  - Latch mul_a = (issue_signed & a[MSB]) ? -a : a, truncated to WIDTH bits. mul_b is computed the same way from b.
  - neg = issue_signed & (a[MSB] ^ b[MSB]). Latch the tag. cnt = LAT-1.
- EXEC: mul_a and mul_b are stable.
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: wb_data = neg ? (~mul_p + 1) : mul_p, masked to 2*WIDTH bits. wb_tag = latched tag. wb_req <= 1. State -> WAIT_WB.
  - Result: wb_req first high LAT cycles after the accept edge.
- WAIT_WB: wb_req, wb_data and wb_tag are held constant.
  - Edge with wb_grant: wb_req <= 0, state -> IDLE. issue_ready rises the following cycle; there is no accept in the grant cycle.
  - wb_grant while not in WAIT_WB is ignored.
- Magnitude edge case: -2^(WIDTH-1) gives magnitude 0x8000, which is correct as unsigned. A negated zero product is 0.
- flush (synchronous): from any state -> IDLE with wb_req <= 0.
  - mul_a, mul_b and wb_data keep their values; wb_req gates their validity.
  - flush in the same cycle as issue_valid blocks the accept.
  - flush in the same cycle as wb_grant: flush wins, and the result counts as not delivered.
- Only one operation is in flight; there is no operand buffering.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-EXEC -> state IDLE, wb_req=0, wb_data=0, issue_ready=1 after release.
- Unsigned, LAT=3: a=0xFFFF, b=0xFFFF, signed=0, tag=5 -> wb_req rises 3 cycles after accept with wb_data=0xFFFE0001, wb_tag=5. Hold wb_grant=0 for 4 cycles -> outputs unchanged. Grant -> IDLE.
- Signed: a=0xFFFD (-3), b=0x0007 -> mul_a=0x0003, mul_b=0x0007, wb_data=0xFFFFFFEB. a=0x8000, b=0x8000 -> mul_a=mul_b=0x8000, wb_data=0x40000000. a=0x8000, b=0x0001 -> wb_data=0xFFFF8000.
- Sign-corrected zero: a=0x0000, b=0xFFFF, signed=1 -> wb_data=0x00000000.
- Handshake: issue_valid held high across two ops -> second accept only the cycle after the grant. issue_ready=0 throughout EXEC and WAIT_WB.
- Flush: flush in EXEC cycle 2 -> IDLE next edge, no wb_req. Flush coincident with wb_grant -> wb_req drops, IDLE. Flush coincident with issue_valid in IDLE -> no accept, busy stays 0.
